// File: rtl/tag_window_counter.sv
// Counts tag edges per channel over consecutive fixed-length tag-time windows and
// streams each closed window's counts out over AXI-Stream, one beat per channel.
module tag_window_counter #(
  parameter int NUM_CHANNELS  = 32,
  parameter int COUNT_WIDTH   = 32,
  parameter bit COUNT_FALLING = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] window_len,
  input  logic        valid_tag,
  input  logic [4:0]  channel,
  input  logic        rising_edge,
  input  logic [63:0] tagtime,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [15:0] dropped_windows,
  output logic [31:0] window_count,
  output logic [1:0]  dbg_count_state,
  output logic        dbg_rd_state
);

  // Stream handshake: a beat transfers on a rising clk edge where m_axis_tvalid && m_axis_tready;
  // once tvalid rises, tvalid/tdata/tuser/tlast hold until that transfer happens.

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, COUNT = 2'd2} cnt_state_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_SEND = 1'b1} rd_state_t;

  localparam int         OW       = (COUNT_WIDTH < 32) ? COUNT_WIDTH : 32;
  localparam logic [4:0] LAST_IDX = 5'(NUM_CHANNELS - 1);

  cnt_state_t state, state_nx;
  rd_state_t  rd_state, rd_nx;

  logic [63:0]            start, len;
  logic [COUNT_WIDTH-1:0] active [32];
  logic [COUNT_WIDTH-1:0] shadow [32];
  logic [4:0]             idx;
  logic                   rd_gap;

  logic [64:0] end_sum, end2_sum;
  logic        tag_ok, first_tag, close, count_in, gap_now;
  logic        hs, final_hs, capture, drop;

  always_comb begin
    // 65-bit sums: a window whose end overflows 64 bits can never be reached by tagtime.
    end_sum   = {1'b0, start} + {1'b0, len};
    end2_sum  = end_sum + {1'b0, len};
    tag_ok    = valid_tag && ({27'd0, channel} < 32'(NUM_CHANNELS)) &&
                (rising_edge || COUNT_FALLING);
    first_tag = (state == ARM) && enable && valid_tag;
    close     = (state == COUNT) && enable && valid_tag && ({1'b0, tagtime} >= end_sum);
    count_in  = (state == COUNT) && enable && valid_tag && !close;
    gap_now   = {1'b0, tagtime} >= end2_sum;
    hs        = m_axis_tvalid && m_axis_tready;
    final_hs  = (rd_state == RD_SEND) && hs && (idx == LAST_IDX);
    capture   = close && ((rd_state == RD_IDLE) || final_hs);
    drop      = close && !capture;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable && (window_len != 64'd0)) state_nx = ARM;
      ARM:     if (!enable) state_nx = IDLE;
               else if (valid_tag) state_nx = COUNT;
      COUNT:   if (!enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_nx = rd_state;
    case (rd_state)
      RD_IDLE: if (capture) rd_nx = RD_SEND;
      RD_SEND: if (final_hs && !capture) rd_nx = RD_IDLE;
      default: rd_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rd_state        <= RD_IDLE;
      start           <= '0;
      len             <= '0;
      idx             <= '0;
      rd_gap          <= 1'b0;
      dropped_windows <= '0;
      window_count    <= '0;
      for (int i = 0; i < 32; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      state    <= state_nx;
      rd_state <= rd_nx;

      if (first_tag) begin
        start <= tagtime;
        len   <= window_len;
      end else if (close) begin
        start <= gap_now ? tagtime : end_sum[63:0];
      end

      // The opening/closing tag is the first count of the fresh window.
      if (first_tag || close) begin
        for (int i = 0; i < 32; i++) active[i] <= '0;
        if (tag_ok) active[channel] <= COUNT_WIDTH'(1);
      end else if (count_in && tag_ok && (active[channel] != '1)) begin
        active[channel] <= active[channel] + COUNT_WIDTH'(1);
      end

      if (close) window_count <= window_count + 32'd1;
      if (drop && (dropped_windows != 16'hffff)) dropped_windows <= dropped_windows + 16'd1;

      if (capture) begin
        for (int i = 0; i < 32; i++) shadow[i] <= active[i];
        rd_gap <= gap_now;
        idx    <= '0;
      end else if (final_hs) begin
        idx <= '0;
      end else if (hs) begin
        idx <= idx + 5'd1;
      end
    end
  end

  assign m_axis_tvalid   = (rd_state == RD_SEND);
  assign m_axis_tdata    = 32'(shadow[idx][OW-1:0]);
  assign m_axis_tuser    = {2'b00, rd_gap, idx};
  assign m_axis_tlast    = m_axis_tvalid && (idx == LAST_IDX);
  assign dbg_count_state = state;
  assign dbg_rd_state    = rd_state;

endmodule

// File: tb/tb_tag_window_counter.sv
// Bench for tag_window_counter: 32 channels, 8-bit counters, rising edges only.
module tb_tag_window_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] window_len = '0;
  logic        valid_tag = 1'b0;
  logic [4:0]  channel = '0;
  logic        rising_edge = 1'b0;
  logic [63:0] tagtime = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [7:0]  m_axis_tuser;
  logic        m_axis_tlast;
  logic [15:0] dropped_windows;
  logic [31:0] window_count;
  logic [1:0]  dbg_count_state;
  logic        dbg_rd_state;

  tag_window_counter #(
    .NUM_CHANNELS (32),
    .COUNT_WIDTH  (8),
    .COUNT_FALLING(1'b0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .window_len     (window_len),
    .valid_tag      (valid_tag),
    .channel        (channel),
    .rising_edge    (rising_edge),
    .tagtime        (tagtime),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .dropped_windows(dropped_windows),
    .window_count   (window_count),
    .dbg_count_state(dbg_count_state),
    .dbg_rd_state   (dbg_rd_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: beats packed as {tlast, tuser, tdata}
  logic [40:0] exp_q[$];
  logic [40:0] got_q[$];
  int exp_cnt[32];
  int n_cmp = 0;
  int n_bad = 0;
  int timeouts = 0;

  task automatic clear_cnt();
    for (int i = 0; i < 32; i++) exp_cnt[i] = 0;
  endtask

  task automatic push_frame(input logic gap);
    for (int i = 0; i < 32; i++)
      exp_q.push_back({(i == 31), 2'b00, gap, 5'(i), 32'(exp_cnt[i])});
  endtask

  // driver tasks: called and return at posedge+1
  task automatic send_tag(input logic [4:0] ch, input logic rise, input logic [63:0] t);
    valid_tag   = 1'b1;
    channel     = ch;
    rising_edge = rise;
    tagtime     = t;
    @(posedge clk); #1;
    valid_tag = 1'b0;
  endtask

  task automatic recv_beats(input int n);
    int waited;
    m_axis_tready = 1'b1;
    for (int b = 0; b < n; b++) begin
      waited = 0;
      while (m_axis_tvalid !== 1'b1 && waited < 100) begin
        @(posedge clk); #1;
        waited++;
      end
      if (m_axis_tvalid !== 1'b1) begin
        timeouts++;
        break;
      end
      got_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
      @(posedge clk); #1;
    end
    m_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tdata !== 32'd0) begin n_bad++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
    n_cmp++; if (m_axis_tuser !== 8'd0) begin n_bad++; $display("FAIL rst_tuser: got %h want 0", m_axis_tuser); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
    n_cmp++; if (dropped_windows !== 16'd0) begin n_bad++; $display("FAIL rst_dropped: got %0d want 0", dropped_windows); end
    n_cmp++; if (window_count !== 32'd0) begin n_bad++; $display("FAIL rst_wcount: got %0d want 0", window_count); end
    n_cmp++; if (dbg_count_state !== 2'd0 || dbg_rd_state !== 1'b0) begin
      n_bad++; $display("FAIL rst_state: got %0d/%0d want 0/0", dbg_count_state, dbg_rd_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [40:0] e, g;
    enable = 1'b1;
    window_len = 64'd1000;
    repeat (2) begin @(posedge clk); #1; end
    send_tag(5'd0, 1'b1, 64'd100);
    send_tag(5'd0, 1'b1, 64'd200);
    send_tag(5'd0, 1'b1, 64'd300);
    send_tag(5'd3, 1'b1, 64'd500);
    clear_cnt(); exp_cnt[0] = 3; exp_cnt[3] = 1; push_frame(1'b0);
    send_tag(5'd1, 1'b1, 64'd1100);
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL basic_latency: tvalid got %b want 1", m_axis_tvalid); end
    recv_beats(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL basic_frame1: got %h want %h", g, e); end
    end
    n_cmp++; if (window_count !== 32'd1) begin n_bad++; $display("FAIL basic_wcount1: got %0d want 1", window_count); end
    clear_cnt(); exp_cnt[1] = 1; push_frame(1'b0);
    send_tag(5'd5, 1'b1, 64'd2100);
    recv_beats(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL basic_frame2: got %h want %h", g, e); end
    end
    n_cmp++; if (window_count !== 32'd2) begin n_bad++; $display("FAIL basic_wcount2: got %0d want 2", window_count); end
  endtask

  task automatic test_stall();
    logic [40:0] e, g;
    window_len = 64'd7;  // must not affect the running window
    send_tag(5'd7, 1'b1, 64'd3099);
    clear_cnt(); exp_cnt[5] = 1; exp_cnt[7] = 1; push_frame(1'b0);
    send_tag(5'd9, 1'b1, 64'd3100);
    recv_beats(10);
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL stall_pre: got %h want %h", g, e); end
    end
    for (int k = 0; k < 20; k++) begin
      n_cmp++;
      if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tuser, m_axis_tdata} !== exp_q[0]) begin
        n_bad++;
        $display("FAIL stall_hold: cycle %0d tvalid %b beat %h want %h", k, m_axis_tvalid,
                 {m_axis_tlast, m_axis_tuser, m_axis_tdata}, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    recv_beats(22);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL stall_post: got %h want %h", g, e); end
    end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL stall_end_tvalid: got %b want 0", m_axis_tvalid); end
  endtask

  task automatic test_drop();
    logic [40:0] e, g;
    send_tag(5'd4, 1'b1, 64'd3600);
    clear_cnt(); exp_cnt[9] = 1; exp_cnt[4] = 1; push_frame(1'b0);
    send_tag(5'd10, 1'b1, 64'd4100);
    send_tag(5'd11, 1'b1, 64'd5100);
    send_tag(5'd12, 1'b1, 64'd6100);
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (dropped_windows !== 16'd2) begin n_bad++; $display("FAIL drop_count: got %0d want 2", dropped_windows); end
    n_cmp++; if (window_count !== 32'd6) begin n_bad++; $display("FAIL drop_wcount: got %0d want 6", window_count); end
    recv_beats(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL drop_frame: got %h want %h", g, e); end
    end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL drop_extra_frame: tvalid got %b want 0", m_axis_tvalid); end
  endtask

  task automatic test_gap();
    logic [40:0] e, g;
    clear_cnt(); exp_cnt[12] = 1; push_frame(1'b1);
    send_tag(5'd2, 1'b1, 64'd12000);
    recv_beats(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL gap_frame: got %h want %h", g, e); end
    end
    send_tag(5'd6, 1'b1, 64'd12999);
    clear_cnt(); exp_cnt[2] = 1; exp_cnt[6] = 1; push_frame(1'b0);
    send_tag(5'd0, 1'b1, 64'd13000);
    recv_beats(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL gap_next_window: got %h want %h", g, e); end
    end
    n_cmp++; if (window_count !== 32'd8) begin n_bad++; $display("FAIL gap_wcount: got %0d want 8", window_count); end
  endtask

  task automatic test_saturate_filter();
    logic [40:0] e, g;
    for (int k = 0; k < 261; k++) send_tag(5'd2, 1'b1, 64'd13100);
    send_tag(5'd3, 1'b0, 64'd13200);
    clear_cnt(); exp_cnt[0] = 1; exp_cnt[2] = 255; push_frame(1'b0);
    send_tag(5'd1, 1'b1, 64'd14000);
    recv_beats(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL sat_frame: got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [40:0] e, g;
    window_len = 64'd1000;
    clear_cnt(); exp_cnt[1] = 1; push_frame(1'b0);
    send_tag(5'd0, 1'b1, 64'd15000);
    recv_beats(10);
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rstmid_pre: got %h want %h", g, e); end
    end
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tuser, m_axis_tdata} !== exp_q[0]) begin
      n_bad++; $display("FAIL rstmid_beat10: tvalid %b beat %h want %h", m_axis_tvalid,
                        {m_axis_tlast, m_axis_tuser, m_axis_tdata}, exp_q[0]);
    end
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rstmid_tvalid: got %b want 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL rstmid_tlast: got %b want 0", m_axis_tlast); end
    n_cmp++; if (window_count !== 32'd0) begin n_bad++; $display("FAIL rstmid_wcount: got %0d want 0", window_count); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++; if (dbg_count_state !== 2'd1) begin n_bad++; $display("FAIL rstmid_arm: state got %0d want 1", dbg_count_state); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle_tvalid: got %b want 0", m_axis_tvalid); end
    send_tag(5'd3, 1'b1, 64'd20000);
    send_tag(5'd3, 1'b1, 64'd20500);
    clear_cnt(); exp_cnt[3] = 2; push_frame(1'b0);
    send_tag(5'd4, 1'b1, 64'd21000);
    recv_beats(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (got_q.size() > 0) g = got_q.pop_front();
      n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rstmid_rearm_frame: got %h want %h", g, e); end
    end
    n_cmp++; if (window_count !== 32'd1) begin n_bad++; $display("FAIL rstmid_wcount_after: got %0d want 1", window_count); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_drop();
    test_gap();
    test_saturate_filter();
    test_reset_midstream();
    n_cmp++; if (timeouts !== 0) begin n_bad++; $display("FAIL beat_timeouts: got %0d want 0", timeouts); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
